// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared types for the pipeline hazard sequencer: FSM state encoding and the
// per-stage control word, with its all-zero bubble value.
package pipeline_hazard_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_BOOT,
        ST_RUN,
        ST_MEM_WAIT,
        ST_ERROR
    } hazard_state_e;

    typedef struct packed {
        logic pc_en;
        logic pc_redirect;
        logic if_id_en;
        logic id_ex_en;
        logic ex_mem_en;
        logic mem_wb_en;
        logic if_id_flush;
        logic id_ex_flush;
        logic mem_wb_bubble;
    } stage_ctrl_t;

    // Bubble: every pipeline control field deasserted.
    localparam stage_ctrl_t CTRL_BUBBLE = '0;

    localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/pipeline_hazard_ctrl_load_use_detect.sv
// Combinational load-use comparator: flags an ID instruction that reads the
// destination of a load currently in EX (x0 never creates a dependency).
module load_use_detect
    import pipeline_hazard_ctrl_pkg::*;
(
    input  logic [4:0] id_rs1,
    input  logic [4:0] id_rs2,
    input  logic       id_uses_rs1,
    input  logic       id_uses_rs2,
    input  logic [4:0] ex_rd,
    input  logic       ex_mem_to_reg,
    output logic       load_use
);

    logic rs1_hit;
    logic rs2_hit;

    assign rs1_hit  = id_uses_rs1 && (id_rs1 == ex_rd);
    assign rs2_hit  = id_uses_rs2 && (id_rs2 == ex_rd);
    assign load_use = ex_mem_to_reg && (ex_rd != REG_ZERO) && (rs1_hit || rs2_hit);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline sequencer: boot hold, memory-wait freeze with timeout, branch
// redirect flush and load-use interlock, plus saturating stall/flush counters.
module pipeline_hazard_ctrl
    import pipeline_hazard_ctrl_pkg::*;
#(
    parameter int unsigned BOOT_CYCLES = 4,
    parameter int unsigned MEM_TIMEOUT = 255,
    parameter int unsigned CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_uses_rs1,
    input  logic             id_uses_rs2,
    input  logic [4:0]       ex_rd,
    input  logic             ex_mem_to_reg,
    input  logic             ex_redirect,
    input  logic             mem_req,
    input  logic             mem_ack,
    output logic             pc_en,
    output logic             pc_redirect,
    output logic             if_id_en,
    output logic             id_ex_en,
    output logic             ex_mem_en,
    output logic             mem_wb_en,
    output logic             if_id_flush,
    output logic             id_ex_flush,
    output logic             mem_wb_bubble,
    output logic             mem_err,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_count
);

    localparam int unsigned BOOT_W = $clog2(BOOT_CYCLES + 1);
    localparam int unsigned WAIT_W = $clog2(MEM_TIMEOUT + 1);
    localparam logic [BOOT_W-1:0] BOOT_LAST = BOOT_W'(BOOT_CYCLES - 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX  = WAIT_W'(MEM_TIMEOUT);

    hazard_state_e     state, state_next;
    logic [BOOT_W-1:0] boot_cnt;
    logic [WAIT_W-1:0] wait_cnt, wait_cnt_next;
    stage_ctrl_t       ctrl;
    logic              load_use;
    logic              mem_stall;
    logic              stall_inc;
    logic              flush_inc;

    load_use_detect u_load_use_detect (
        .id_rs1        (id_rs1),
        .id_rs2        (id_rs2),
        .id_uses_rs1   (id_uses_rs1),
        .id_uses_rs2   (id_uses_rs2),
        .ex_rd         (ex_rd),
        .ex_mem_to_reg (ex_mem_to_reg),
        .load_use      (load_use)
    );

    // An ack without a request is meaningless and simply ignored here.
    assign mem_stall = mem_req && !mem_ack;

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        ctrl          = CTRL_BUBBLE;
        state_next    = state;
        wait_cnt_next = wait_cnt;
        stall_inc     = 1'b0;
        flush_inc     = 1'b0;
        case (state)
            ST_BOOT: begin
                ctrl.if_id_flush   = 1'b1;
                ctrl.id_ex_flush   = 1'b1;
                ctrl.mem_wb_bubble = 1'b1;
                if (boot_cnt == BOOT_LAST) state_next = ST_RUN;
            end
            ST_RUN, ST_MEM_WAIT: begin
                if (mem_stall) begin
                    // Freeze everything upstream; WB drains with a bubble.
                    ctrl.mem_wb_en     = 1'b1;
                    ctrl.mem_wb_bubble = 1'b1;
                    stall_inc          = 1'b1;
                    wait_cnt_next      = wait_cnt + WAIT_W'(1);
                    state_next         = (wait_cnt_next == WAIT_MAX) ? ST_ERROR : ST_MEM_WAIT;
                end else begin
                    state_next    = ST_RUN;
                    wait_cnt_next = '0;
                    ctrl.id_ex_en  = 1'b1;
                    ctrl.ex_mem_en = 1'b1;
                    ctrl.mem_wb_en = 1'b1;
                    if (ex_redirect) begin
                        // The redirect squashes the dependent instruction, so it wins over load-use.
                        ctrl.pc_en       = 1'b1;
                        ctrl.if_id_en    = 1'b1;
                        ctrl.pc_redirect = 1'b1;
                        ctrl.if_id_flush = 1'b1;
                        ctrl.id_ex_flush = 1'b1;
                        flush_inc        = 1'b1;
                    end else if (load_use) begin
                        ctrl.id_ex_flush = 1'b1;
                        stall_inc        = 1'b1;
                    end else begin
                        ctrl.pc_en    = 1'b1;
                        ctrl.if_id_en = 1'b1;
                    end
                end
            end
            ST_ERROR: begin
                state_next = ST_ERROR;
            end
            default: begin
                state_next = ST_BOOT;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= ST_BOOT;
            boot_cnt     <= '0;
            wait_cnt     <= '0;
            mem_err      <= 1'b0;
            stall_cycles <= '0;
            flush_count  <= '0;
        end else begin
            state    <= state_next;
            wait_cnt <= wait_cnt_next;
            if (state == ST_BOOT && boot_cnt != BOOT_LAST) boot_cnt <= boot_cnt + BOOT_W'(1);
            if (state_next == ST_ERROR) mem_err <= 1'b1;
            // Counters stick at all-ones rather than wrapping.
            if (stall_inc && stall_cycles != '1) stall_cycles <= stall_cycles + CNT_W'(1);
            if (flush_inc && flush_count != '1) flush_count <= flush_count + CNT_W'(1);
        end
    end

    assign pc_en         = ctrl.pc_en;
    assign pc_redirect   = ctrl.pc_redirect;
    assign if_id_en      = ctrl.if_id_en;
    assign id_ex_en      = ctrl.id_ex_en;
    assign ex_mem_en     = ctrl.ex_mem_en;
    assign mem_wb_en     = ctrl.mem_wb_en;
    assign if_id_flush   = ctrl.if_id_flush;
    assign id_ex_flush   = ctrl.id_ex_flush;
    assign mem_wb_bubble = ctrl.mem_wb_bubble;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench: directed hazard scenarios plus random traffic, compared
// each cycle against a rule-level model; a narrow-counter copy checks saturation.
module tb_pipeline_hazard_ctrl;

    localparam int BOOT    = 4;
    localparam int TIMEOUT = 8;
    localparam int SAT_W   = 3;
    localparam int SAT_MAX = (1 << SAT_W) - 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [4:0] id_rs1 = '0, id_rs2 = '0, ex_rd = '0;
    logic id_uses_rs1 = 1'b0, id_uses_rs2 = 1'b0, ex_mem_to_reg = 1'b0;
    logic ex_redirect = 1'b0, mem_req = 1'b0, mem_ack = 1'b0;

    logic pc_en, pc_redirect, if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
    logic if_id_flush, id_ex_flush, mem_wb_bubble, mem_err;
    logic [31:0] stall_cycles, flush_count;

    logic s_pc_en, s_pc_redirect, s_if_id_en, s_id_ex_en, s_ex_mem_en, s_mem_wb_en;
    logic s_if_id_flush, s_id_ex_flush, s_mem_wb_bubble, s_mem_err;
    logic [SAT_W-1:0] s_stall_cycles, s_flush_count;

    int checks   = 0;
    int failures = 0;

    // Model state: boot cycles remaining, dead after timeout, consecutive waits, raw totals.
    int m_boot_left;
    bit m_dead;
    int m_consec;
    int m_stalls;
    int m_flushes;

    always #5 clk = ~clk;

    pipeline_hazard_ctrl #(.BOOT_CYCLES(BOOT), .MEM_TIMEOUT(TIMEOUT), .CNT_W(32)) dut (
        .clk(clk), .rst(rst),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
        .ex_rd(ex_rd), .ex_mem_to_reg(ex_mem_to_reg), .ex_redirect(ex_redirect),
        .mem_req(mem_req), .mem_ack(mem_ack),
        .pc_en(pc_en), .pc_redirect(pc_redirect), .if_id_en(if_id_en), .id_ex_en(id_ex_en),
        .ex_mem_en(ex_mem_en), .mem_wb_en(mem_wb_en), .if_id_flush(if_id_flush),
        .id_ex_flush(id_ex_flush), .mem_wb_bubble(mem_wb_bubble), .mem_err(mem_err),
        .stall_cycles(stall_cycles), .flush_count(flush_count)
    );

    pipeline_hazard_ctrl #(.BOOT_CYCLES(BOOT), .MEM_TIMEOUT(TIMEOUT), .CNT_W(SAT_W)) dut_sat (
        .clk(clk), .rst(rst),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
        .ex_rd(ex_rd), .ex_mem_to_reg(ex_mem_to_reg), .ex_redirect(ex_redirect),
        .mem_req(mem_req), .mem_ack(mem_ack),
        .pc_en(s_pc_en), .pc_redirect(s_pc_redirect), .if_id_en(s_if_id_en), .id_ex_en(s_id_ex_en),
        .ex_mem_en(s_ex_mem_en), .mem_wb_en(s_mem_wb_en), .if_id_flush(s_if_id_flush),
        .id_ex_flush(s_id_ex_flush), .mem_wb_bubble(s_mem_wb_bubble), .mem_err(s_mem_err),
        .stall_cycles(s_stall_cycles), .flush_count(s_flush_count)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
        end
    endtask

    function automatic bit model_load_use();
        return ex_mem_to_reg && (ex_rd != 5'd0) &&
               ((id_uses_rs1 && id_rs1 == ex_rd) || (id_uses_rs2 && id_rs2 == ex_rd));
    endfunction

    // Control word order: pc_en pc_redirect if_id_en id_ex_en ex_mem_en mem_wb_en if_id_flush id_ex_flush mem_wb_bubble
    function automatic logic [8:0] model_ctrl();
        if (m_dead)                      return 9'b000000000;
        if (m_boot_left > 0)             return 9'b000000111;
        if (mem_req && !mem_ack)         return 9'b000001001;
        if (ex_redirect)                 return 9'b111111110;
        if (model_load_use())            return 9'b000111010;
        return 9'b101111000;
    endfunction

    function automatic int sat(input int v);
        return (v > SAT_MAX) ? SAT_MAX : v;
    endfunction

    task automatic compare_outputs();
        logic [8:0] exp_ctrl;
        exp_ctrl = model_ctrl();
        check("ctrl", {pc_en, pc_redirect, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
                       if_id_flush, id_ex_flush, mem_wb_bubble}, exp_ctrl);
        check("ctrl_sat", {s_pc_en, s_pc_redirect, s_if_id_en, s_id_ex_en, s_ex_mem_en, s_mem_wb_en,
                           s_if_id_flush, s_id_ex_flush, s_mem_wb_bubble}, exp_ctrl);
        check("mem_err", mem_err, m_dead);
        check("stall_cycles", stall_cycles, m_stalls);
        check("flush_count", flush_count, m_flushes);
        check("stall_cycles_sat", s_stall_cycles, sat(m_stalls));
        check("flush_count_sat", s_flush_count, sat(m_flushes));
    endtask

    // Advance the model across the coming rising edge.
    task automatic model_edge();
        if (m_dead) return;
        if (m_boot_left > 0) begin
            m_boot_left--;
        end else if (mem_req && !mem_ack) begin
            m_stalls++;
            m_consec++;
            if (m_consec == TIMEOUT) m_dead = 1'b1;
        end else begin
            m_consec = 0;
            if (ex_redirect)           m_flushes++;
            else if (model_load_use()) m_stalls++;
        end
    endtask

    task automatic drive(input logic [4:0] rs1, input logic [4:0] rs2, input logic u1, input logic u2,
                         input logic [4:0] rd, input logic m2r, input logic redir,
                         input logic req, input logic ack);
        id_rs1 = rs1; id_rs2 = rs2; id_uses_rs1 = u1; id_uses_rs2 = u2;
        ex_rd = rd; ex_mem_to_reg = m2r; ex_redirect = redir; mem_req = req; mem_ack = ack;
    endtask

    // Called just after a falling edge; returns on the next falling edge.
    task automatic step();
        #1;
        compare_outputs();
        model_edge();
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        m_boot_left = BOOT;
        m_dead = 1'b0;
        m_consec = 0;
        m_stalls = 0;
        m_flushes = 0;
        #1;
        compare_outputs();
        rst = 1'b0;
    endtask

    initial begin
        do_reset();
        for (int i = 0; i < BOOT; i++) step();
        check("boot_stall_lit", stall_cycles, 0);
        check("boot_flush_lit", flush_count, 0);

        drive(0, 0, 0, 0, 0, 0, 0, 0, 0); step();
        drive(1, 5, 0, 1, 5, 1, 0, 0, 0); step();
        check("load_use_lit", stall_cycles, 1);
        drive(0, 0, 1, 1, 0, 1, 0, 0, 0); step();
        check("load_use_x0_lit", stall_cycles, 1);
        drive(0, 0, 0, 0, 0, 0, 1, 0, 0); step();
        check("redirect_lit", flush_count, 1);

        drive(0, 0, 0, 0, 0, 0, 0, 1, 0); step(); step(); step();
        drive(0, 0, 0, 0, 0, 0, 0, 1, 1); step();
        check("mem_wait_lit", stall_cycles, 4);

        drive(3, 0, 1, 0, 3, 1, 1, 0, 0); step();
        check("redir_vs_lu_lit", flush_count, 2);
        check("redir_vs_lu_stall_lit", stall_cycles, 4);

        drive(0, 0, 0, 0, 0, 0, 1, 1, 0); step(); step();
        check("deferred_redir_hold_lit", flush_count, 2);
        drive(0, 0, 0, 0, 0, 0, 1, 1, 1); step();
        check("deferred_redir_lit", flush_count, 3);

        drive(0, 0, 0, 0, 0, 0, 0, 1, 0);
        for (int i = 0; i < TIMEOUT; i++) step();
        check("timeout_err_lit", mem_err, 1);
        check("timeout_stall_lit", stall_cycles, 14);
        check("sat_stall_lit", s_stall_cycles, SAT_MAX);
        drive(0, 0, 1, 0, 0, 0, 1, 0, 1); step(); step();
        check("error_hold_lit", flush_count, 3);

        do_reset();
        check("reset_from_err_lit", mem_err, 0);
        for (int i = 0; i < BOOT; i++) step();

        for (int n = 0; n < 4000; n++) begin
            if ($urandom_range(0, 499) == 0 || (m_dead && $urandom_range(0, 9) == 0)) begin
                do_reset();
            end
            id_rs1        = 5'($urandom_range(0, 3));
            id_rs2        = 5'($urandom_range(0, 3));
            id_uses_rs1   = 1'($urandom_range(0, 1));
            id_uses_rs2   = 1'($urandom_range(0, 1));
            ex_rd         = 5'($urandom_range(0, 3));
            ex_mem_to_reg = 1'($urandom_range(0, 1));
            ex_redirect   = ($urandom_range(0, 5) == 0);
            mem_req       = ($urandom_range(0, 2) == 0);
            mem_ack       = mem_req ? ($urandom_range(0, 9) < 5) : ($urandom_range(0, 4) == 0);
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
- Sequencer for the 5-stage pipeline. Drives per-stage register enables and flushes from the decoded EX/MEM/WB control bits and register indices.
- Resolves four conditions: load-use interlock, taken-branch/jump redirect, variable-latency data-memory wait, and post-reset boot hold.
- Sits beside the decode control unit and the pipeline registers. Holds the stall FSM, memory-wait timeout and stall/flush performance counters.

Parameters:
- BOOT_CYCLES, 4: cycles the pipeline is held and flushed after reset release (>=1).
- MEM_TIMEOUT, 255: consecutive memory-wait cycles before a fatal timeout (>=1).
- CNT_W, 32: width of the performance counters.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- id_rs1  in  5  rs1 index of the instruction in ID.
- id_rs2  in  5  rs2 index of the instruction in ID.
- id_uses_rs1  in  1  the ID instruction reads rs1.
- id_uses_rs2  in  1  the ID instruction reads rs2.
- ex_rd  in  5  destination register of the instruction in EX.
- ex_mem_to_reg  in  1  the EX instruction is a load (WB MemtoReg bit).
- ex_redirect  in  1  the EX instruction is a taken branch or a jump (JAL/JALR).
- mem_req  in  1  the MEM instruction accesses data memory (load or store).
- mem_ack  in  1  data memory completes the access this cycle.
- pc_en  out  1  PC register load enable.
- pc_redirect  out  1  PC selects the EX-computed target.
- if_id_en, id_ex_en, ex_mem_en, mem_wb_en  out  1 each  pipeline register enables.
- if_id_flush, id_ex_flush  out  1 each  load a bubble (all control bits 0) on the next edge.
- mem_wb_bubble  out  1  MEM/WB loads a bubble instead of MEM results.
- mem_err  out  1  sticky memory-timeout flag.
- stall_cycles  out  CNT_W  count of cycles with pc_en=0 in RUN/MEM_WAIT.
- flush_count  out  CNT_W  count of redirects taken.

Behaviour:
- Stage controls are combinational (Mealy) on state and inputs. State, wait counter, boot counter and perf counters are registered.
- FSM states: BOOT, RUN, MEM_WAIT, ERROR. Reset enters BOOT with all counters at 0 and mem_err=0.
- BOOT: all enables=0, pc_redirect=0, if_id_flush=id_ex_flush=mem_wb_bubble=1. Moves to RUN after BOOT_CYCLES cycles, i.e. the first RUN cycle is cycle BOOT_CYCLES after reset release.
- Derived terms:
  - mem_stall = mem_req & !mem_ack
  - load_use = ex_mem_to_reg & ex_rd!=0 & ((id_uses_rs1 & id_rs1==ex_rd) | (id_uses_rs2 & id_rs2==ex_rd))
- RUN and MEM_WAIT share one priority order.
  1. mem_stall: pc_en, if_id_en, id_ex_en, ex_mem_en = 0; mem_wb_en=1 with mem_wb_bubble=1; no flush, no redirect. The state becomes MEM_WAIT.
  2. ex_redirect: all enables=1, pc_redirect=1, if_id_flush=id_ex_flush=1. flush_count increments.
  3. load_use: pc_en=if_id_en=0, id_ex_en=1 with id_ex_flush=1, ex_mem_en=mem_wb_en=1.
  4. Otherwise: all enables=1, no flush.
- Redirect beats load-use: the dependent instruction is flushed, so no bubble is needed. A redirect held in EX during a memory wait is taken in the cycle mem_ack arrives.
- MEM_WAIT tracking: the wait counter increments each mem_stall cycle. mem_ack returns the FSM to RUN, and that cycle is evaluated as RUN with mem_stall=0.
- Timeout: if the counter reaches MEM_TIMEOUT with no ack, the FSM moves to ERROR on that edge. The counter clears on entering RUN.
- ERROR: all enables=0, mem_err=1; held until rst.
- mem_req=0 with mem_ack=1 is ignored.
- Counters saturate at all-ones and never wrap. They are readable in every state.
- Asserting rst in any state returns to BOOT immediately (asynchronously). A pending memory access is abandoned; the memory side must drop mem_ack on reset.

Decomposition:
- Shared package: FSM state enum (BOOT, RUN, MEM_WAIT, ERROR) and a bubble constant for the pipeline-register control fields (all zero).
- One sub-module, load_use_detect: purely combinational comparator producing load_use, reusable by a later forwarding unit.

Test Plan:
- Reset with BOOT_CYCLES=4 -> 4 cycles of enables=0 and flushes=1, then RUN on the 5th cycle after release; counters read 0.
- Load in EX (ex_rd=5) and ID reads rs2=5 -> one cycle pc_en=0, id_ex_flush=1; stall_cycles=1. Same case with ex_rd=0 -> no stall.
- ex_redirect=1 in RUN -> pc_redirect=1, if_id_flush=id_ex_flush=1 for one cycle; flush_count=1.
- mem_req=1, mem_ack arriving on the 4th cycle -> 3 frozen cycles with mem_wb_bubble=1, normal advance on the ack cycle; stall_cycles=3.
- ex_redirect and load_use together -> redirect only, no id_ex bubble. Redirect during a memory wait -> deferred to the ack cycle.
- MEM_TIMEOUT=8, mem_req held with no ack -> ERROR after 8 wait cycles, mem_err=1 and all enables 0 until rst, then BOOT.
